regfile_dp_param: RTL and testbench

- Parametrised successor of the single 32-bit dual-write/dual-read register.
- Holds DEPTH words of WIDTH bits.
- Two prioritised write ports: C is the control path and wins; V is the vector/filter path.
- Two independent addressed read ports (A, B) with optional write bypass, per-entry valid tracking and a registered write-collision flag.
- Sits between the filter datapath and the control unit as the shared working-register bank.

---
 rtl/regfile_dp_param_pkg.sv | 20 ++
 rtl/regfile_read_port.sv | 54 +++++
 rtl/regfile_dp_param.sv | 97 +++++++++
 tb/tb_regfile_dp_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dp_param_pkg.sv
// Shared helpers for the dual-port working-register bank.
package regfile_dp_param_pkg;

  // Ceiling log2, clamped to at least 1 so a one-entry bank still has an address bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Byte-lane merge: the caller loops over the lanes of a word, so each lane
  // returns the new byte when its enable is set and keeps the old byte otherwise.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One addressed read port: range check, optional write bypass, valid lookup
// and the zero/Z output select for a deselected port.
module regfile_read_port
  import regfile_dp_param_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter bit BYPASS  = 1'b0,
  parameter bit UNSEL_Z = 1'b0
) (
  input  logic             cs,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] mem [DEPTH],
  input  logic [DEPTH-1:0] valid_bits,
  input  logic             wc,
  input  logic [AW-1:0]    addr_c,
  input  logic [WIDTH-1:0] merged_c,
  input  logic             wv,
  input  logic [AW-1:0]    addr_v,
  input  logic [WIDTH-1:0] din_v,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  logic             in_range;
  logic [WIDTH-1:0] data;
  logic             vld;

  assign in_range = 32'(addr) < DEPTH;

  // Select stored word or, with bypass, the word this edge will commit (C beats V).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    data = '0;
    vld  = 1'b0;
    if (in_range) begin
      if (BYPASS && wc && (addr == addr_c)) begin
        data = merged_c;
        vld  = 1'b1;
      end else if (BYPASS && wv && (addr == addr_v)) begin
        data = din_v;
        vld  = 1'b1;
      end else begin
        data = mem[addr];
        vld  = valid_bits[addr];
      end
    end
  end

  assign dout  = cs ? data : (UNSEL_Z ? {WIDTH{1'bz}} : {WIDTH{1'b0}});
  assign valid = cs & vld;

endmodule

// File: rtl/regfile_dp_param.sv
// Shared working-register bank between the filter datapath and the control unit.
// Two prioritised write ports (C = control, wins; V = vector path), two
// combinational read ports, per-entry valid bits and a registered collision flag.
// All state changes on the falling clock edge.
module regfile_dp_param
  import regfile_dp_param_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               BYPASS      = 1'b0,
  parameter bit               UNSEL_Z     = 1'b0,
  localparam int              AW          = clog2(DEPTH),
  localparam int              BYTES       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CSa,
  input  logic [AW-1:0]    addr_a,
  output logic [WIDTH-1:0] DoA,
  output logic             valid_a,
  input  logic             CSb,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] DoB,
  output logic             valid_b,
  input  logic             CSc,
  input  logic             WEc,
  input  logic [AW-1:0]    addr_c,
  input  logic [BYTES-1:0] be_c,
  input  logic [WIDTH-1:0] DinC,
  input  logic             CSv,
  input  logic             WEv,
  input  logic [AW-1:0]    addr_v,
  input  logic [WIDTH-1:0] DinV,
  output logic             collision
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_bits;
  logic             wc;
  logic             wv;
  logic             same_addr;
  logic [WIDTH-1:0] merged_c;

  // Out-of-range addresses never strobe, so they touch neither data, valid nor collision.
  assign wc        = CSc & WEc & (|be_c) & (32'(addr_c) < DEPTH);
  assign wv        = CSv & WEv & (32'(addr_v) < DEPTH);
  assign same_addr = wc & wv & (addr_c == addr_v);

  // Byte-merge C's data into the entry it addresses; unused when wc is low.
  always_comb begin
    merged_c = '0;
    for (int i = 0; i < BYTES; i++) begin
      merged_c[8*i +: 8] = byte_merge(mem[addr_c][8*i +: 8], DinC[8*i +: 8], be_c[i]);
    end
  end

  // Falling-edge storage update: reset, then V (dropped on a clash), then C.
  always_ff @(negedge clk) begin
    if (rst) begin
      // NOTE: the array is built from flops, so a reset loop over every entry is legal here; a RAM macro would not allow it.
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
      valid_bits <= '0;
      collision  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      collision <= same_addr;
      if (wv && !same_addr) begin
        mem[addr_v]        <= DinV;
        valid_bits[addr_v] <= 1'b1;
      end
      if (wc) begin
        mem[addr_c]        <= merged_c;
        valid_bits[addr_c] <= 1'b1;
      end
    end
  end

  regfile_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS), .UNSEL_Z(UNSEL_Z)
  ) u_port_a (
    .cs(CSa), .addr(addr_a), .mem(mem), .valid_bits(valid_bits),
    .wc(wc), .addr_c(addr_c), .merged_c(merged_c),
    .wv(wv), .addr_v(addr_v), .din_v(DinV),
    .dout(DoA), .valid(valid_a)
  );

  regfile_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS), .UNSEL_Z(UNSEL_Z)
  ) u_port_b (
    .cs(CSb), .addr(addr_b), .mem(mem), .valid_bits(valid_bits),
    .wc(wc), .addr_c(addr_c), .merged_c(merged_c),
    .wv(wv), .addr_v(addr_v), .din_v(DinV),
    .dout(DoB), .valid(valid_b)
  );

endmodule

// File: tb/tb_regfile_dp_param.sv
// Directed bench for regfile_dp_param. Two instances share all stimulus:
//   dut0: DEPTH=16, RESET_VALUE=0, BYPASS=0, UNSEL_Z=0
//   dut1: DEPTH=12, RESET_VALUE=5A5A5A5A, BYPASS=1, UNSEL_Z=1
// dut1 outputs are pulled high, so a released (Z) port reads as all ones.
module tb_regfile_dp_param;

  localparam logic [31:0] RV1 = 32'h5A5A_5A5A;

  logic        clk;
  logic        rst;
  logic        cs_a, cs_b, cs_c, we_c, cs_v, we_v;
  logic [3:0]  addr_a, addr_b, addr_c, addr_v;
  logic [3:0]  be_c;
  logic [31:0] din_c, din_v;

  logic [31:0] do_a0, do_b0;
  logic        valid_a0, valid_b0, coll0;
  tri1  [31:0] do_a1, do_b1;
  logic        valid_a1, valid_b1, coll1;

  int checks;
  int errors;

  regfile_dp_param #(
    .WIDTH(32), .DEPTH(16), .RESET_VALUE(32'h0), .BYPASS(1'b0), .UNSEL_Z(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .CSa(cs_a), .addr_a(addr_a), .DoA(do_a0), .valid_a(valid_a0),
    .CSb(cs_b), .addr_b(addr_b), .DoB(do_b0), .valid_b(valid_b0),
    .CSc(cs_c), .WEc(we_c), .addr_c(addr_c), .be_c(be_c), .DinC(din_c),
    .CSv(cs_v), .WEv(we_v), .addr_v(addr_v), .DinV(din_v),
    .collision(coll0)
  );

  regfile_dp_param #(
    .WIDTH(32), .DEPTH(12), .RESET_VALUE(RV1), .BYPASS(1'b1), .UNSEL_Z(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .CSa(cs_a), .addr_a(addr_a), .DoA(do_a1), .valid_a(valid_a1),
    .CSb(cs_b), .addr_b(addr_b), .DoB(do_b1), .valid_b(valid_b1),
    .CSc(cs_c), .WEc(we_c), .addr_c(addr_c), .be_c(be_c), .DinC(din_c),
    .CSv(cs_v), .WEv(we_v), .addr_v(addr_v), .DinV(din_v),
    .collision(coll1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_writes();
    cs_c = 1'b0; we_c = 1'b0; addr_c = '0; be_c = '0; din_c = '0;
    cs_v = 1'b0; we_v = 1'b0; addr_v = '0; din_v = '0;
  endtask

  task automatic write_c(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    cs_c = 1'b1; we_c = 1'b1; addr_c = a; be_c = be; din_c = d;
  endtask

  task automatic write_v(input logic [3:0] a, input logic [31:0] d);
    cs_v = 1'b1; we_v = 1'b1; addr_v = a; din_v = d;
  endtask

  task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
    cs_a = 1'b1; addr_a = a; cs_b = 1'b1; addr_b = b;
    #1;
  endtask

  // Reset with a clashing full write active: reset must win everywhere.
  task automatic test_reset();
    rst = 1'b1;
    cs_a = 1'b0; addr_a = '0; cs_b = 1'b0; addr_b = '0;
    write_c(4'd1, 4'hF, 32'h5555_5555);
    write_v(4'd1, 32'hAAAA_AAAA);
    tick();
    idle_writes();
    #1;
    checks++; if (coll0 !== 1'b0) begin errors++; $display("FAIL reset_coll0: got %b expected 0", coll0); end
    checks++; if (coll1 !== 1'b0) begin errors++; $display("FAIL reset_coll1: got %b expected 0", coll1); end
    for (int i = 0; i < 12; i++) begin
      read_ab(4'(i), 4'(i));
      checks++; if (do_a0 !== 32'h0) begin errors++; $display("FAIL reset_a0[%0d]: got %h expected 00000000", i, do_a0); end
      checks++; if (do_b1 !== RV1) begin errors++; $display("FAIL reset_b1[%0d]: got %h expected %h", i, do_b1, RV1); end
      checks++; if ({valid_a0, valid_b0, valid_a1, valid_b1} !== 4'b0000) begin
        errors++; $display("FAIL reset_valid[%0d]: got %b expected 0000", i, {valid_a0, valid_b0, valid_a1, valid_b1});
      end
    end
    rst = 1'b0;
    tick();
    read_ab(4'd1, 4'd1);
    checks++; if (do_a0 !== 32'h0) begin errors++; $display("FAIL reset_hold_a0: got %h expected 00000000", do_a0); end
    checks++; if (do_a1 !== RV1) begin errors++; $display("FAIL reset_hold_a1: got %h expected %h", do_a1, RV1); end
  endtask

  // Partial-byte write from C over a word written by V.
  task automatic test_byte_enable();
    write_v(4'd3, 32'h1122_3344);
    tick();
    idle_writes();
    write_c(4'd3, 4'b0101, 32'hAABB_CCDD);
    read_ab(4'd3, 4'd3);
    checks++; if (do_a0 !== 32'h1122_3344) begin errors++; $display("FAIL be_pre_a0: got %h expected 11223344", do_a0); end
    checks++; if (do_a1 !== 32'h11BB_33DD) begin errors++; $display("FAIL be_bypass_a1: got %h expected 11bb33dd", do_a1); end
    checks++; if (valid_a1 !== 1'b1) begin errors++; $display("FAIL be_bypass_valid_a1: got %b expected 1", valid_a1); end
    tick();
    idle_writes();
    #1;
    checks++; if (do_a0 !== 32'h11BB_33DD) begin errors++; $display("FAIL be_post_a0: got %h expected 11bb33dd", do_a0); end
    checks++; if (do_b1 !== 32'h11BB_33DD) begin errors++; $display("FAIL be_post_b1: got %h expected 11bb33dd", do_b1); end
    checks++; if (valid_a0 !== 1'b1) begin errors++; $display("FAIL be_post_valid_a0: got %b expected 1", valid_a0); end
  endtask

  // C and V to different addresses on the same edge: both commit, no collision.
  task automatic test_dual_diff();
    write_c(4'd2, 4'hF, 32'hDEAD_BEEF);
    write_v(4'd5, 32'h1234_5678);
    tick();
    idle_writes();
    read_ab(4'd2, 4'd5);
    checks++; if (do_a0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL diff_a0: got %h expected deadbeef", do_a0); end
    checks++; if (do_b0 !== 32'h1234_5678) begin errors++; $display("FAIL diff_b0: got %h expected 12345678", do_b0); end
    checks++; if (do_a1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL diff_a1: got %h expected deadbeef", do_a1); end
    checks++; if (do_b1 !== 32'h1234_5678) begin errors++; $display("FAIL diff_b1: got %h expected 12345678", do_b1); end
    checks++; if ({coll0, coll1} !== 2'b00) begin errors++; $display("FAIL diff_coll: got %b expected 00", {coll0, coll1}); end
  endtask

  // Same-address clash: C wins whole word, collision pulses for one period.
  // Then a C request with be_c=0 is no write at all, so V commits alone.
  task automatic test_dual_same();
    write_c(4'd7, 4'b0001, 32'h0000_00FF);
    write_v(4'd7, 32'hFFFF_FFFF);
    read_ab(4'd7, 4'd7);
    checks++; if (do_a1 !== 32'h5A5A_5AFF) begin errors++; $display("FAIL same_bypass_a1: got %h expected 5a5a5aff", do_a1); end
    tick();
    idle_writes();
    #1;
    checks++; if (do_a0 !== 32'h0000_00FF) begin errors++; $display("FAIL same_a0: got %h expected 000000ff", do_a0); end
    checks++; if (do_a1 !== 32'h5A5A_5AFF) begin errors++; $display("FAIL same_a1: got %h expected 5a5a5aff", do_a1); end
    checks++; if ({coll0, coll1} !== 2'b11) begin errors++; $display("FAIL same_coll_set: got %b expected 11", {coll0, coll1}); end
    tick();
    checks++; if ({coll0, coll1} !== 2'b00) begin errors++; $display("FAIL same_coll_clear: got %b expected 00", {coll0, coll1}); end
    write_c(4'd8, 4'b0000, 32'h1111_1111);
    write_v(4'd8, 32'h0BAD_F00D);
    tick();
    idle_writes();
    read_ab(4'd8, 4'd8);
    checks++; if (do_a0 !== 32'h0BAD_F00D) begin errors++; $display("FAIL be0_a0: got %h expected 0badf00d", do_a0); end
    checks++; if (do_b1 !== 32'h0BAD_F00D) begin errors++; $display("FAIL be0_b1: got %h expected 0badf00d", do_b1); end
    checks++; if ({coll0, coll1} !== 2'b00) begin errors++; $display("FAIL be0_coll: got %b expected 00", {coll0, coll1}); end
  endtask

  // Read of an address being written by V: bypass instance sees new word early.
  task automatic test_bypass();
    write_v(4'd4, 32'hCAFE_F00D);
    read_ab(4'd4, 4'd4);
    checks++; if (do_a0 !== 32'h0) begin errors++; $display("FAIL byp_pre_a0: got %h expected 00000000", do_a0); end
    checks++; if (valid_a0 !== 1'b0) begin errors++; $display("FAIL byp_pre_valid_a0: got %b expected 0", valid_a0); end
    checks++; if (do_a1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL byp_pre_a1: got %h expected cafef00d", do_a1); end
    checks++; if (valid_a1 !== 1'b1) begin errors++; $display("FAIL byp_pre_valid_a1: got %b expected 1", valid_a1); end
    tick();
    idle_writes();
    #1;
    checks++; if (do_a0 !== 32'hCAFE_F00D) begin errors++; $display("FAIL byp_post_a0: got %h expected cafef00d", do_a0); end
    checks++; if (valid_a0 !== 1'b1) begin errors++; $display("FAIL byp_post_valid_a0: got %b expected 1", valid_a0); end
  endtask

  // Deselected port output, then a clashing write at address 13:
  // in range for dut0 (DEPTH 16), out of range for dut1 (DEPTH 12).
  task automatic test_deselect_range();
    cs_a = 1'b1; addr_a = 4'd2; cs_b = 1'b0; addr_b = 4'd2;
    #1;
    checks++; if (do_b0 !== 32'h0) begin errors++; $display("FAIL desel_b0: got %h expected 00000000", do_b0); end
    checks++; if (do_b1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL desel_b1_released: got %h expected ffffffff", do_b1); end
    checks++; if ({valid_b0, valid_b1} !== 2'b00) begin errors++; $display("FAIL desel_valid: got %b expected 00", {valid_b0, valid_b1}); end
    write_c(4'd13, 4'hF, 32'h1313_1313);
    write_v(4'd13, 32'h7777_7777);
    cs_a = 1'b1; addr_a = 4'd13;
    #1;
    checks++; if (do_a1 !== 32'h0) begin errors++; $display("FAIL oor_bypass_a1: got %h expected 00000000", do_a1); end
    checks++; if (valid_a1 !== 1'b0) begin errors++; $display("FAIL oor_bypass_valid_a1: got %b expected 0", valid_a1); end
    tick();
    idle_writes();
    #1;
    checks++; if (do_a0 !== 32'h1313_1313) begin errors++; $display("FAIL oor_a0: got %h expected 13131313", do_a0); end
    checks++; if (coll0 !== 1'b1) begin errors++; $display("FAIL oor_coll0: got %b expected 1", coll0); end
    checks++; if (do_a1 !== 32'h0) begin errors++; $display("FAIL oor_a1: got %h expected 00000000", do_a1); end
    checks++; if (valid_a1 !== 1'b0) begin errors++; $display("FAIL oor_valid_a1: got %b expected 0", valid_a1); end
    checks++; if (coll1 !== 1'b0) begin errors++; $display("FAIL oor_coll1: got %b expected 0", coll1); end
  endtask

  // Idle edges, then sweep every address on both ports against the hand-built image.
  task automatic test_hold_sweep();
    logic [31:0] exp0 [16];
    logic [31:0] exp1 [16];
    logic [15:0] vmask0;
    logic [15:0] vmask1;
    for (int i = 0; i < 16; i++) begin
      exp0[i] = 32'h0;
      exp1[i] = (i < 12) ? RV1 : 32'h0;
    end
    exp0[2] = 32'hDEAD_BEEF; exp1[2] = 32'hDEAD_BEEF;
    exp0[3] = 32'h11BB_33DD; exp1[3] = 32'h11BB_33DD;
    exp0[4] = 32'hCAFE_F00D; exp1[4] = 32'hCAFE_F00D;
    exp0[5] = 32'h1234_5678; exp1[5] = 32'h1234_5678;
    exp0[7] = 32'h0000_00FF; exp1[7] = 32'h5A5A_5AFF;
    exp0[8] = 32'h0BAD_F00D; exp1[8] = 32'h0BAD_F00D;
    exp0[13] = 32'h1313_1313;
    vmask1 = 16'b0000_0001_1011_1100;
    vmask0 = 16'b0010_0001_1011_1100;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      read_ab(4'(i), 4'(i));
      checks++; if (do_a0 !== exp0[i] || do_b0 !== exp0[i]) begin
        errors++; $display("FAIL sweep0[%0d]: got a=%h b=%h expected %h", i, do_a0, do_b0, exp0[i]);
      end
      checks++; if (do_a1 !== exp1[i] || do_b1 !== exp1[i]) begin
        errors++; $display("FAIL sweep1[%0d]: got a=%h b=%h expected %h", i, do_a1, do_b1, exp1[i]);
      end
      checks++; if (valid_a0 !== vmask0[i] || valid_b0 !== vmask0[i] || valid_a1 !== vmask1[i] || valid_b1 !== vmask1[i]) begin
        errors++; $display("FAIL sweep_valid[%0d]: got %b%b%b%b expected %b%b%b%b", i,
                           valid_a0, valid_b0, valid_a1, valid_b1, vmask0[i], vmask0[i], vmask1[i], vmask1[i]);
      end
    end
    checks++; if ({coll0, coll1} !== 2'b00) begin errors++; $display("FAIL sweep_coll: got %b expected 00", {coll0, coll1}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    cs_a = 1'b0; addr_a = '0; cs_b = 1'b0; addr_b = '0;
    idle_writes();
    test_reset();
    test_byte_enable();
    test_dual_diff();
    test_dual_same();
    test_bypass();
    test_deselect_range();
    test_hold_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
